// File: rtl/data_inf_sync_fifo.sv
// ============================================================================
// data_inf_sync_fifo
// ----------------------------------------------------------------------------
// Single-clock valid/ready buffer for data_inf streams. Words arrive on the
// slaver side and leave on the master side in order. The head entry is shown
// combinationally (first-word-fall-through). With PACKET_MODE=1 the master
// side only presents data once a complete packet (terminated by slaver_last)
// is stored. A packet too large to fit is force-released so the buffer
// cannot deadlock.
//
// Ports:
//   clock         in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   flush         in   synchronous clear of contents (slaver_ready unaffected)
//   slaver_data   in   write data [DSIZE]
//   slaver_last   in   end-of-packet marker stored alongside the data
//   slaver_valid  in   write request
//   slaver_ready  out  space available (not full, not in reset)
//   master_data   out  head-of-FIFO data [DSIZE]
//   master_last   out  head-of-FIFO last bit
//   master_valid  out  head entry presentable
//   master_ready  in   consumer accepts the head entry
//   count         out  number of stored entries [$clog2(DEPTH+1)]
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   pkt_oversize  out  one-cycle pulse when an oversize packet is released
// ============================================================================
module data_inf_sync_fifo #(
    parameter int DSIZE       = 8,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0,
    parameter int AF_LEVEL    = DEPTH - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DSIZE-1:0]           slaver_data,
    input  logic                       slaver_last,
    input  logic                       slaver_valid,
    output logic                       slaver_ready,
    output logic [DSIZE-1:0]           master_data,
    output logic                       master_last,
    output logic                       master_valid,
    input  logic                       master_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       pkt_oversize
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] AF_THRESH = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_THRESH = CW'(AE_LEVEL);
    localparam logic          PKT_EN    = (PACKET_MODE != 0);

    // In packet mode the output is either holding back incomplete packets
    // or, after an oversize packet filled the buffer, releasing it.
    typedef enum logic {
        GATE_HOLD,
        GATE_RELEASE
    } gate_e;

    logic [DSIZE:0]  mem_q [DEPTH];
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   pktCnt_q, pktCnt_d;
    gate_e           gate_q, gate_d;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            clear;
    logic            pushLast;
    logic            popLast;
    logic            releaseSet;
    logic            pktReady;
    logic [DSIZE:0]  headEntry;

    // Pointers carry one extra wrap bit so that full and empty can be told
    // apart without a separate flag: equal means empty, equal except for the
    // wrap bit means full.
    assign empty = (wrPtr_q == rdPtr_q);
    assign full  = (wrPtr_q[PW-1] != rdPtr_q[PW-1]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign clear = rst || flush;

    // slaver_ready only looks at stored state (and reset), never at
    // master_ready, so a full buffer refuses writes even while it is popped.
    assign slaver_ready = !full && !rst;

    // Head of the buffer is driven straight from the array so a stored word
    // is visible the cycle after it is written.
    assign headEntry   = mem_q[rdPtr_q[AW-1:0]];
    assign master_data = headEntry[DSIZE-1:0];
    assign master_last = headEntry[DSIZE];

    // An oversize packet has filled the buffer without any complete packet
    // stored: it must be released now or nothing could ever move again.
    assign releaseSet = PKT_EN && full && (pktCnt_q == '0) && (gate_q == GATE_HOLD);

    // The head beat may leave if a complete packet is stored or if the
    // current (oversize) packet is being released.
    assign pktReady = (pktCnt_q != '0) || (gate_q == GATE_RELEASE) || releaseSet;

    assign master_valid = !rst && !empty && (!PKT_EN || pktReady);
    assign pkt_oversize = !rst && releaseSet;

    assign push     = slaver_valid && slaver_ready;
    assign pop      = master_valid && master_ready;
    assign pushLast = push && slaver_last;
    assign popLast  = pop && master_last;

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_THRESH);
    assign almost_empty = (count_q <= AE_THRESH);

    // Next-state for the pointers, the fill count and the complete-packet
    // count. Simultaneous push and pop leave both counts unchanged.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        pktCnt_d = pktCnt_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case ({pushLast, popLast})
            2'b10:   pktCnt_d = pktCnt_q + CW'(1);
            2'b01:   pktCnt_d = pktCnt_q - CW'(1);
            default: pktCnt_d = pktCnt_q;
        endcase
    end

    // Release gate: once an oversize packet is released it keeps flowing
    // until its last beat leaves, even if the buffer drains completely and
    // the remaining beats trickle in afterwards.
    always_comb begin
        gate_d = gate_q;
        case (gate_q)
            GATE_HOLD: begin
                if (releaseSet) begin
                    gate_d = GATE_RELEASE;
                end
            end
            GATE_RELEASE: begin
                if (popLast) begin
                    gate_d = GATE_HOLD;
                end
            end
            default: gate_d = GATE_HOLD;
        endcase
    end

    // State registers. Reset and flush both discard the contents and ignore
    // any handshake happening in the same cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            pktCnt_q <= '0;
            gate_q   <= GATE_HOLD;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            pktCnt_q <= pktCnt_d;
            gate_q   <= gate_d;
        end
    end

    // Storage array: data and last bit are written together. It has no
    // reset because empty pointers already hide stale contents.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem_q[wrPtr_q[AW-1:0]] <= {slaver_last, slaver_data};
        end
    end

endmodule

// File: tb/tb_data_inf_sync_fifo.sv
// ============================================================================
// tb_data_inf_sync_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for data_inf_sync_fifo. Two instances share one clock:
// a stream-mode buffer (DEPTH=16) and a packet-mode buffer (DEPTH=4).
// Accepted writes push the expected word into a per-instance queue; a
// monitor pops and compares whenever the DUT hands a word over.
// ============================================================================
module tb_data_inf_sync_fifo;

    bit          clock;

    // Stream-mode instance signals
    logic        sRst, sFlush;
    logic [7:0]  sSData;
    logic        sSLast, sSValid, sSReady;
    logic [7:0]  sMData;
    logic        sMLast, sMValid, sMReady;
    logic [4:0]  sCount;
    logic        sAF, sAE, sOvr;

    // Packet-mode instance signals
    logic        pRst, pFlush;
    logic [7:0]  pSData;
    logic        pSLast, pSValid, pSReady;
    logic [7:0]  pMData;
    logic        pMLast, pMValid, pMReady;
    logic [2:0]  pCount;
    logic        pAF, pAE, pOvr;

    logic [8:0]  sExp[$];
    logic [8:0]  pExp[$];

    int          testsRun;
    int          failCount;

    data_inf_sync_fifo #(
        .DSIZE(8), .DEPTH(16), .PACKET_MODE(0), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dutStream (
        .clock(clock), .rst(sRst), .flush(sFlush),
        .slaver_data(sSData), .slaver_last(sSLast), .slaver_valid(sSValid),
        .slaver_ready(sSReady),
        .master_data(sMData), .master_last(sMLast), .master_valid(sMValid),
        .master_ready(sMReady),
        .count(sCount), .almost_full(sAF), .almost_empty(sAE),
        .pkt_oversize(sOvr)
    );

    data_inf_sync_fifo #(
        .DSIZE(8), .DEPTH(4), .PACKET_MODE(1), .AF_LEVEL(2), .AE_LEVEL(2)
    ) dutPacket (
        .clock(clock), .rst(pRst), .flush(pFlush),
        .slaver_data(pSData), .slaver_last(pSLast), .slaver_valid(pSValid),
        .slaver_ready(pSReady),
        .master_data(pMData), .master_last(pMLast), .master_valid(pMValid),
        .master_ready(pMReady),
        .count(pCount), .almost_full(pAF), .almost_empty(pAE),
        .pkt_oversize(pOvr)
    );

    // 10 ns clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle on the selected instance; the other instance idles.
    // 'accept' is the bench's own prediction that the write is taken.
    task automatic applyStimulus(input bit pkt, input bit v, input logic [7:0] d,
                                 input bit l, input bit r, input bit accept);
        if (pkt) begin
            pSValid = v; pSData = d; pSLast = l; pMReady = r;
            sSValid = 1'b0; sMReady = 1'b0;
            if (accept) pExp.push_back({l, d});
        end else begin
            sSValid = v; sSData = d; sSLast = l; sMReady = r;
            pSValid = 1'b0; pMReady = 1'b0;
            if (accept) sExp.push_back({l, d});
        end
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitors: sample mid-cycle, a handshake seen here completes
    // at the next rising edge.
    always @(negedge clock) begin
        logic [8:0] expWord;
        if (sRst === 1'b0 && sFlush === 1'b0 && sMValid === 1'b1 && sMReady === 1'b1) begin
            if (sExp.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL stream_extra_pop: got %0h, required no output", {sMLast, sMData});
            end else begin
                expWord = sExp.pop_front();
                checkOutput("stream_pop", 32'({sMLast, sMData}), 32'(expWord));
            end
        end
    end

    always @(negedge clock) begin
        logic [8:0] expWord;
        if (pRst === 1'b0 && pFlush === 1'b0 && pMValid === 1'b1 && pMReady === 1'b1) begin
            if (pExp.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL packet_extra_pop: got %0h, required no output", {pMLast, pMData});
            end else begin
                expWord = pExp.pop_front();
                checkOutput("packet_pop", 32'({pMLast, pMData}), 32'(expWord));
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sRst = 1'b1; sFlush = 1'b0; sSData = '0; sSLast = 1'b0; sSValid = 1'b0; sMReady = 1'b0;
        pRst = 1'b1; pFlush = 1'b0; pSData = '0; pSLast = 1'b0; pSValid = 1'b0; pMReady = 1'b0;
        testsRun = 0;
        failCount = 0;

        // ---------------- Reset state ----------------
        @(posedge clock);
        #1;
        checkOutput("rst_s_ready", 32'(sSReady), 0);
        checkOutput("rst_s_count", 32'(sCount), 0);
        checkOutput("rst_s_valid", 32'(sMValid), 0);
        checkOutput("rst_s_af", 32'(sAF), 0);
        checkOutput("rst_s_ae", 32'(sAE), 1);
        checkOutput("rst_s_ovr", 32'(sOvr), 0);
        checkOutput("rst_p_ready", 32'(pSReady), 0);
        checkOutput("rst_p_count", 32'(pCount), 0);
        checkOutput("rst_p_valid", 32'(pMValid), 0);
        sRst = 1'b0;
        pRst = 1'b0;
        #1;
        checkOutput("post_rst_s_ready", 32'(sSReady), 1);
        checkOutput("post_rst_p_ready", 32'(pSReady), 1);

        // ---------------- Stream fill ----------------
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 8'(i), (i == 15), 0, 1);
            checkOutput("fill_count", 32'(sCount), 32'(i + 1));
            checkOutput("fill_af", 32'(sAF), 32'((i + 1) >= 14));
            checkOutput("fill_ae", 32'(sAE), 32'((i + 1) <= 2));
            checkOutput("fill_ready", 32'(sSReady), 32'((i + 1) < 16));
            checkOutput("fill_valid", 32'(sMValid), 1);
        end
        // write attempt while full is refused
        applyStimulus(0, 1, 8'h99, 0, 0, 0);
        checkOutput("full_refuse_count", 32'(sCount), 16);
        // push + pop at full: push refused, pop succeeds
        applyStimulus(0, 1, 8'h77, 0, 1, 0);
        checkOutput("full_pp_count", 32'(sCount), 15);
        checkOutput("full_pp_ready", 32'(sSReady), 1);

        // ---------------- Stream drain ----------------
        for (int k = 14; k >= 0; k--) begin
            applyStimulus(0, 0, 8'h00, 0, 1, 0);
            checkOutput("drain_count", 32'(sCount), 32'(k));
            checkOutput("drain_ae", 32'(sAE), 32'(k <= 2));
            checkOutput("drain_valid", 32'(sMValid), 32'(k != 0));
        end

        // ---------------- Push + pop at count=1 ----------------
        applyStimulus(0, 1, 8'h11, 0, 0, 1);
        checkOutput("one_count", 32'(sCount), 1);
        applyStimulus(0, 1, 8'h22, 0, 1, 1);
        checkOutput("one_pp_count", 32'(sCount), 1);
        applyStimulus(0, 0, 8'h00, 0, 1, 0);
        checkOutput("one_end_count", 32'(sCount), 0);
        checkOutput("one_end_valid", 32'(sMValid), 0);

        // ---------------- FWFT latency ----------------
        applyStimulus(0, 1, 8'hA5, 0, 0, 1);
        checkOutput("fwft_valid", 32'(sMValid), 1);
        checkOutput("fwft_data", 32'(sMData), 32'hA5);
        applyStimulus(0, 0, 8'h00, 0, 1, 0);
        checkOutput("fwft_empty", 32'(sMValid), 0);

        // ---------------- Flush mid-operation ----------------
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 8'(8'h30 + i), 0, 0, 1);
        end
        checkOutput("pre_flush_count", 32'(sCount), 5);
        sFlush = 1'b1;
        applyStimulus(0, 1, 8'h55, 0, 1, 0);
        sFlush = 1'b0;
        sSValid = 1'b0;
        sMReady = 1'b0;
        sExp.delete();
        checkOutput("flush_count", 32'(sCount), 0);
        checkOutput("flush_valid", 32'(sMValid), 0);
        checkOutput("flush_ready", 32'(sSReady), 1);

        // ---------------- Reset mid-operation ----------------
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 8'(8'h40 + i), 0, 0, 1);
        end
        sRst = 1'b1;
        #1;
        checkOutput("rst_mid_ready_now", 32'(sSReady), 0);
        applyStimulus(0, 1, 8'h66, 0, 0, 0);
        sExp.delete();
        checkOutput("rst_mid_ready", 32'(sSReady), 0);
        checkOutput("rst_mid_count", 32'(sCount), 0);
        checkOutput("rst_mid_valid", 32'(sMValid), 0);
        checkOutput("rst_mid_af", 32'(sAF), 0);
        checkOutput("rst_mid_ae", 32'(sAE), 1);
        checkOutput("rst_mid_ovr", 32'(sOvr), 0);
        sRst = 1'b0;
        sSValid = 1'b0;
        #1;
        checkOutput("rst_mid_release_ready", 32'(sSReady), 1);

        // ---------------- Packet mode: 3-beat packet ----------------
        applyStimulus(1, 1, 8'hB0, 0, 0, 1);
        checkOutput("pkt_b1_valid", 32'(pMValid), 0);
        applyStimulus(1, 1, 8'hB1, 0, 0, 1);
        checkOutput("pkt_b2_valid", 32'(pMValid), 0);
        applyStimulus(1, 1, 8'hB2, 1, 0, 1);
        checkOutput("pkt_b3_valid", 32'(pMValid), 1);
        checkOutput("pkt_b3_count", 32'(pCount), 3);
        // first beat of second packet fills the buffer, no forced release
        applyStimulus(1, 1, 8'hC0, 0, 0, 1);
        checkOutput("pkt2_full_ready", 32'(pSReady), 0);
        checkOutput("pkt2_full_ovr", 32'(pOvr), 0);
        checkOutput("pkt2_full_af", 32'(pAF), 1);
        applyStimulus(1, 0, 8'h00, 0, 1, 0);
        checkOutput("pkt_drain1_valid", 32'(pMValid), 1);
        applyStimulus(1, 0, 8'h00, 0, 1, 0);
        checkOutput("pkt_drain2_valid", 32'(pMValid), 1);
        applyStimulus(1, 0, 8'h00, 0, 1, 0);
        checkOutput("pkt2_hidden_valid", 32'(pMValid), 0);
        checkOutput("pkt2_hidden_count", 32'(pCount), 1);
        applyStimulus(1, 1, 8'hC1, 1, 0, 1);
        checkOutput("pkt2_complete_valid", 32'(pMValid), 1);
        applyStimulus(1, 0, 8'h00, 0, 1, 0);
        checkOutput("pkt2_drain1_valid", 32'(pMValid), 1);
        applyStimulus(1, 0, 8'h00, 0, 1, 0);
        checkOutput("pkt2_empty_valid", 32'(pMValid), 0);
        checkOutput("pkt2_empty_count", 32'(pCount), 0);

        // ---------------- Packet mode: oversize packet ----------------
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 8'(8'hD0 + i), 0, 0, 1);
            checkOutput("ovs_fill_valid", 32'(pMValid), 0);
            checkOutput("ovs_fill_ovr", 32'(pOvr), 0);
        end
        applyStimulus(1, 1, 8'hD3, 0, 0, 1);
        checkOutput("ovs_full_ovr", 32'(pOvr), 1);
        checkOutput("ovs_full_valid", 32'(pMValid), 1);
        applyStimulus(1, 0, 8'h00, 0, 0, 0);
        checkOutput("ovs_pulse_once", 32'(pOvr), 0);
        checkOutput("ovs_hold_valid", 32'(pMValid), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 8'h00, 0, 1, 0);
        end
        checkOutput("ovs_drained_count", 32'(pCount), 0);
        checkOutput("ovs_drained_valid", 32'(pMValid), 0);
        applyStimulus(1, 1, 8'hD4, 0, 0, 1);
        checkOutput("ovs_tail_valid", 32'(pMValid), 1);
        applyStimulus(1, 1, 8'hD5, 1, 1, 1);
        checkOutput("ovs_last_count", 32'(pCount), 1);
        checkOutput("ovs_last_valid", 32'(pMValid), 1);
        applyStimulus(1, 0, 8'h00, 0, 1, 0);
        checkOutput("ovs_done_count", 32'(pCount), 0);
        // release is cleared: a new incomplete beat is held back again
        applyStimulus(1, 1, 8'hE0, 0, 0, 1);
        checkOutput("ovs_rel_clear_valid", 32'(pMValid), 0);
        checkOutput("ovs_rel_clear_count", 32'(pCount), 1);
        pFlush = 1'b1;
        applyStimulus(1, 0, 8'h00, 0, 0, 0);
        pFlush = 1'b0;
        pExp.delete();
        checkOutput("pkt_flush_count", 32'(pCount), 0);

        // ---------------- Scoreboards fully consumed ----------------
        checkOutput("stream_sb_left", 32'(sExp.size()), 0);
        checkOutput("packet_sb_left", 32'(pExp.size()), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
